// File: rtl/jtag_ir_dr.sv
`default_nettype none
// ============================================================================
// Module   : jtag_ir_dr
// Purpose  : JTAG instruction register, data-register bank (BYPASS, IDCODE,
//            optional 8-bit USER) and TDO multiplexer. Driven by the one-hot
//            state flags of an upstream TAP controller.
// Ports    : tclk / trst (async, active-low) - test clock and reset
//            tdi                              - serial data in
//            test_logic_reset, capture/shift/update_dr, capture/shift/update_ir
//                                             - TAP state flags
//            user_capture[7:0]                - parallel value captured into USER DR
//            tdo, tdo_en                      - serial data out and its enable
//            ir[IR_WIDTH-1:0]                 - active instruction
//            user_update[7:0], user_update_pulse - USER DR parallel output + strobe
// Config   : JTAG_USER_DR_EN - when defined, builds the USER data register and
//            decodes OP_USER; otherwise OP_USER selects BYPASS and the user
//            outputs are tied low.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_ir_dr #(
  parameter int unsigned         IR_WIDTH   = 4,
  parameter logic [31:0]         IDCODE_VAL = 32'h1000_0A5B,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE  = 4'b0001,
  parameter logic [IR_WIDTH-1:0] OP_USER    = 4'b1000
) (
  input  logic                tclk,
  input  logic                trst,
  input  logic                tdi,
  input  logic                test_logic_reset,
  input  logic                capture_dr,
  input  logic                shift_dr,
  input  logic                update_dr,
  input  logic                capture_ir,
  input  logic                shift_ir,
  input  logic                update_ir,
  input  logic [7:0]          user_capture,
  output logic                tdo,
  output logic                tdo_en,
  output logic [IR_WIDTH-1:0] ir,
  output logic [7:0]          user_update,
  output logic                user_update_pulse
);

  // Value loaded into the IR shift stage on capture: bit0 = 1, bit1 = 0.
  localparam logic [IR_WIDTH-1:0] c_ir_capture = IR_WIDTH'(1);

  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                bypass_q, bypass_d;
  logic [31:0]         id_sr_q, id_sr_d;

  // Single-action-per-edge priority: reset > capture > shift > update,
  // with the IR flag winning over the DR flag at each level.
  logic w_cap_ir, w_cap_dr, w_shf_ir, w_shf_dr, w_upd_ir;
  logic w_no_cap, w_no_shf;
  logic w_sel_idcode, w_sel_user;
  logic w_user_bit0;

  assign w_no_cap = ~test_logic_reset & ~capture_ir & ~capture_dr;
  assign w_no_shf = w_no_cap & ~shift_ir & ~shift_dr;
  assign w_cap_ir = ~test_logic_reset & capture_ir;
  assign w_cap_dr = ~test_logic_reset & ~capture_ir & capture_dr;
  assign w_shf_ir = w_no_cap & shift_ir;
  assign w_shf_dr = w_no_cap & ~shift_ir & shift_dr;
  assign w_upd_ir = w_no_shf & update_ir;

  // Data register selection follows the active instruction every cycle;
  // anything not decoded falls through to BYPASS.
  assign w_sel_idcode = (ir_q == OP_IDCODE);

  always_comb begin
    ir_sr_d  = ir_sr_q;
    ir_d     = ir_q;
    bypass_d = bypass_q;
    id_sr_d  = id_sr_q;
    if (test_logic_reset) begin
      ir_sr_d  = OP_IDCODE;
      ir_d     = OP_IDCODE;
      bypass_d = 1'b0;
      id_sr_d  = '0;
    end else if (w_cap_ir) begin
      ir_sr_d = c_ir_capture;
    end else if (w_cap_dr) begin
      if (w_sel_idcode)     id_sr_d  = IDCODE_VAL;
      else if (!w_sel_user) bypass_d = 1'b0;
    end else if (w_shf_ir) begin
      ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};
    end else if (w_shf_dr) begin
      if (w_sel_idcode)     id_sr_d  = {tdi, id_sr_q[31:1]};
      else if (!w_sel_user) bypass_d = tdi;
    end else if (w_upd_ir) begin
      ir_d = ir_sr_q;
    end
  end

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) begin
      ir_sr_q  <= OP_IDCODE;
      ir_q     <= OP_IDCODE;
      bypass_q <= 1'b0;
      id_sr_q  <= '0;
    end else begin
      ir_sr_q  <= ir_sr_d;
      ir_q     <= ir_d;
      bypass_q <= bypass_d;
      id_sr_q  <= id_sr_d;
    end
  end

`ifdef JTAG_USER_DR_EN
  logic [7:0] user_sr_q, user_sr_d;
  logic [7:0] user_update_q, user_update_d;
  logic       user_pulse_q, user_pulse_d;
  logic       w_upd_dr;

  assign w_upd_dr    = w_no_shf & ~update_ir & update_dr;
  assign w_sel_user  = (ir_q == OP_USER);
  assign w_user_bit0 = user_sr_q[0];

  always_comb begin
    user_sr_d     = user_sr_q;
    user_update_d = user_update_q;
    user_pulse_d  = 1'b0;
    // Test-logic-reset clears the shift stage but keeps the parallel output.
    if (test_logic_reset) begin
      user_sr_d = '0;
    end else if (w_sel_user) begin
      if (w_cap_dr)      user_sr_d = user_capture;
      else if (w_shf_dr) user_sr_d = {tdi, user_sr_q[7:1]};
      else if (w_upd_dr) begin
        user_update_d = user_sr_q;
        user_pulse_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) begin
      user_sr_q     <= '0;
      user_update_q <= '0;
      user_pulse_q  <= 1'b0;
    end else begin
      user_sr_q     <= user_sr_d;
      user_update_q <= user_update_d;
      user_pulse_q  <= user_pulse_d;
    end
  end

  assign user_update       = user_update_q;
  assign user_update_pulse = user_pulse_q;
`else
  // USER register not built: OP_USER compares but never selects anything.
  logic w_unused_user_inputs;
  assign w_unused_user_inputs = ^{user_capture, update_dr, (ir_q == OP_USER)};
  assign w_sel_user           = 1'b0;
  assign w_user_bit0          = 1'b0;
  assign user_update          = 8'h00;
  assign user_update_pulse    = 1'b0;
`endif

  // TDO is purely combinational from register outputs so the bit is stable
  // for the whole shift cycle.
  always_comb begin
    tdo = 1'b0;
    if (shift_ir) begin
      tdo = ir_sr_q[0];
    end else if (shift_dr) begin
      if (w_sel_idcode)    tdo = id_sr_q[0];
      else if (w_sel_user) tdo = w_user_bit0;
      else                 tdo = bypass_q;
    end
  end

  assign tdo_en = shift_ir | shift_dr;
  assign ir     = ir_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_ir_dr.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_ir_dr
// Purpose  : Self-checking bench for jtag_ir_dr. A behavioural model of the
//            IR / DR bank is compared against the DUT on every falling edge;
//            directed scans pin the model with literal expectations, then a
//            randomized phase exercises IR loads, DR scans, resets and the
//            optional USER register (JTAG_USER_DR_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_ir_dr;

`ifdef JTAG_USER_DR_EN
  localparam bit USER_EN = 1'b1;
`else
  localparam bit USER_EN = 1'b0;
`endif
  localparam logic [31:0] IDV = 32'h1000_0A5B;

  // Flag vector order: {tlr, cdr, sdr, udr, cir, sir, uir}
  localparam logic [6:0] F_IDLE = 7'b0000000;
  localparam logic [6:0] F_TLR  = 7'b1000000;
  localparam logic [6:0] F_CDR  = 7'b0100000;
  localparam logic [6:0] F_SDR  = 7'b0010000;
  localparam logic [6:0] F_UDR  = 7'b0001000;
  localparam logic [6:0] F_CIR  = 7'b0000100;
  localparam logic [6:0] F_SIR  = 7'b0000010;
  localparam logic [6:0] F_UIR  = 7'b0000001;

  logic       tclk = 1'b0;
  logic       trst = 1'b0;
  logic       tdi = 1'b0;
  logic       tlr = 1'b0, cdr = 1'b0, sdr = 1'b0, udr = 1'b0;
  logic       cir = 1'b0, sir = 1'b0, uir = 1'b0;
  logic [7:0] ucap = 8'h00;
  logic       tdo, tdo_en, up;
  logic [3:0] ir;
  logic [7:0] uu;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 tclk = ~tclk;

  jtag_ir_dr dut (
    .tclk(tclk), .trst(trst), .tdi(tdi),
    .test_logic_reset(tlr), .capture_dr(cdr), .shift_dr(sdr), .update_dr(udr),
    .capture_ir(cir), .shift_ir(sir), .update_ir(uir),
    .user_capture(ucap), .tdo(tdo), .tdo_en(tdo_en), .ir(ir),
    .user_update(uu), .user_update_pulse(up)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]  m_ir, m_ir_sr;
  logic        m_byp;
  logic [31:0] m_id;
  logic [7:0]  m_usr, m_uu;
  logic        m_pulse;

  // 0 = BYPASS, 1 = IDCODE, 2 = USER
  function automatic int sel();
    if (m_ir == 4'b0001) return 1;
    if (USER_EN && m_ir == 4'b1000) return 2;
    return 0;
  endfunction

  function automatic logic exp_tdo();
    if (sir) return m_ir_sr[0];
    if (sdr) begin
      case (sel())
        1:       return m_id[0];
        2:       return m_usr[0];
        default: return m_byp;
      endcase
    end
    return 1'b0;
  endfunction

  always @(posedge tclk or negedge trst) begin
    if (!trst) begin
      m_ir <= 4'd1; m_ir_sr <= 4'd1; m_byp <= 1'b0; m_id <= 32'd0;
      m_usr <= 8'd0; m_uu <= 8'd0; m_pulse <= 1'b0;
    end else begin
      m_pulse <= 1'b0;
      if (tlr) begin
        m_ir <= 4'd1; m_ir_sr <= 4'd1; m_byp <= 1'b0; m_id <= 32'd0; m_usr <= 8'd0;
      end else if (cir) begin
        m_ir_sr <= 4'd1;
      end else if (cdr) begin
        case (sel())
          1:       m_id  <= IDV;
          2:       m_usr <= ucap;
          default: m_byp <= 1'b0;
        endcase
      end else if (sir) begin
        m_ir_sr <= m_ir_sr / 4'd2 + (tdi ? 4'd8 : 4'd0);
      end else if (sdr) begin
        case (sel())
          1:       m_id  <= m_id / 32'd2 + (tdi ? 32'h8000_0000 : 32'd0);
          2:       m_usr <= m_usr / 8'd2 + (tdi ? 8'h80 : 8'h00);
          default: m_byp <= tdi;
        endcase
      end else if (uir) begin
        m_ir <= m_ir_sr;
      end else if (udr && sel() == 2) begin
        m_uu    <= m_usr;
        m_pulse <= 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge tclk) begin
    if (cmp_en) begin
      chk("tdo", tdo, exp_tdo());
      chk("tdo_en", tdo_en, sir | sdr);
      chk("ir", ir, m_ir);
      chk("user_update", uu, m_uu);
      chk("user_update_pulse", up, m_pulse);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at posedge+1; returns the tdo seen mid-cycle; ends at next posedge+1.
  task automatic tick(input logic [6:0] f, input logic d, output logic o);
    {tlr, cdr, sdr, udr, cir, sir, uir} = f;
    tdi = d;
    @(negedge tclk);
    o = tdo;
    @(posedge tclk);
    #1;
  endtask

  task automatic load_ir(input logic [3:0] op, output logic [3:0] seen);
    logic o;
    tick(F_CIR, 1'b0, o);
    for (int i = 0; i < 4; i++) begin
      tick(F_SIR, op[i], o);
      seen[i] = o;
    end
    tick(F_UIR, 1'b0, o);
  endtask

  initial begin
    logic        o;
    logic [31:0] v32;
    logic [7:0]  v8;
    logic [5:0]  v6;
    logic [3:0]  v4;
    logic [5:0]  byp_in;
    logic [7:0]  usr_in;
    logic [6:0]  f;
    int          r;

    // Reset held across a few edges, then checked.
    trst = 1'b0;
    repeat (3) @(posedge tclk);
    #1;
    cmp_en = 1'b1;
    @(negedge tclk);
    chk("rst_ir", ir, 4'b0001);
    chk("rst_tdo_en", tdo_en, 1'b0);
    chk("rst_tdo", tdo, 1'b0);
    chk("rst_user_update", uu, 8'h00);
    trst = 1'b1;
    @(posedge tclk);
    #1;

    // IDCODE read straight after reset.
    tick(F_CDR, 1'b0, o);
    for (int i = 0; i < 32; i++) begin
      tick(F_SDR, 1'b0, o);
      v32[i] = o;
    end
    chk("idcode_seq", v32, 32'h1000_0A5B);

    // Load BYPASS into IR; captured pattern shows as 1,0,0,0.
    load_ir(4'b1111, v4);
    chk("ir_capture_seq", v4, 4'b0001);
    chk("ir_bypass", ir, 4'b1111);

    // BYPASS: one-cycle delay with a leading zero.
    byp_in = 6'b001101;  // tdi = 1,0,1,1,0,0 (LSB first)
    tick(F_CDR, 1'b0, o);
    for (int i = 0; i < 6; i++) begin
      tick(F_SDR, byp_in[i], o);
      v6[i] = o;
    end
    chk("bypass_seq", v6, 6'b011010);

    // Test-logic-reset for one edge.
    tick(F_TLR, 1'b0, o);
    chk("tlr_ir", ir, 4'b0001);

    // USER register scan.
    load_ir(4'b1000, v4);
    chk("ir_user", ir, 4'b1000);
    ucap   = 8'hC3;
    usr_in = 8'h5A;
    tick(F_CDR, 1'b0, o);
    for (int i = 0; i < 8; i++) begin
      tick(F_SDR, usr_in[i], o);
      v8[i] = o;
    end
    chk("user_tdo_seq", v8, USER_EN ? 8'hC3 : 8'hB4);
    tick(F_UDR, 1'b0, o);
    chk("user_update_val", uu, USER_EN ? 8'h5A : 8'h00);
    chk("user_pulse_hi", up, USER_EN ? 1'b1 : 1'b0);
    tick(F_IDLE, 1'b0, o);
    chk("user_pulse_lo", up, 1'b0);
    chk("user_update_hold", uu, USER_EN ? 8'h5A : 8'h00);

    // test_logic_reset leaves user_update alone.
    tick(F_TLR, 1'b0, o);
    chk("tlr_keeps_user_update", uu, USER_EN ? 8'h5A : 8'h00);

    // Abort an IR scan with trst after 3 of 4 shifts.
    tick(F_CIR, 1'b0, o);
    for (int i = 0; i < 3; i++) tick(F_SIR, 1'b1, o);
    {tlr, cdr, sdr, udr, cir, sir, uir} = F_IDLE;
    trst = 1'b0;
    @(negedge tclk);
    chk("abort_ir", ir, 4'b0001);
    chk("abort_user_update", uu, 8'h00);
    chk("abort_tdo_en", tdo_en, 1'b0);
    #2;
    trst = 1'b1;
    @(posedge tclk);
    #1;
    tick(F_UIR, 1'b0, o);
    chk("abort_update_ir", ir, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      tick(F_SIR, 1'b0, o);
      v4[i] = o;
    end
    chk("abort_ir_sr", v4, 4'b0001);

    // Randomized phase.
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 4);
      case (r)
        0:       load_ir(4'b0001, v4);
        1:       load_ir(4'b1000, v4);
        2:       load_ir(4'b1111, v4);
        3:       load_ir(4'($urandom), v4);
        default: ;
      endcase
      for (int c = 0; c < 16; c++) begin
        ucap = 8'($urandom);
        r = $urandom_range(0, 19);
        case (r)
          0, 1:              f = F_CDR;
          2, 3, 4, 5, 6, 7, 8, 9: f = F_SDR;
          10, 11:            f = F_UDR;
          12:                f = F_CIR;
          13:                f = F_SIR;
          14:                f = F_UIR;
          15:                f = F_TLR | (7'b1 << $urandom_range(0, 5));
          default:           f = F_IDLE;
        endcase
        if ($urandom_range(0, 79) == 0) begin
          #1 trst = 1'b0;
          #1 trst = 1'b1;
        end
        tick(f, 1'($urandom), o);
      end
    end

    cmp_en = 1'b0;
    {tlr, cdr, sdr, udr, cir, sir, uir} = F_IDLE;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
